// File: rtl/iq_free_list.sv
// Circular free list of issue-queue entry IDs: offers up to DISPATCH_WIDTH
// free IDs per cycle, reclaims IDs granted by the issue lanes, and raises
// the IQ-full stall and a sticky overflow error.
module iq_free_list #(
    parameter int unsigned SIZE_ISSUEQ     = 32,
    parameter int unsigned DISPATCH_WIDTH  = 4,
    parameter int unsigned ISSUE_WIDTH     = 4,
    parameter int unsigned SIZE_ISSUEQ_LOG = 5
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush_i,
    input  logic                                      dispatchReady_i,
    input  logic [DISPATCH_WIDTH-1:0]                 dispatchLaneActive_i,
    input  logic [ISSUE_WIDTH-1:0]                    grantedValid_i,
    input  logic [ISSUE_WIDTH*SIZE_ISSUEQ_LOG-1:0]    grantedId_i,
    output logic [DISPATCH_WIDTH*SIZE_ISSUEQ_LOG-1:0] freeEntryId_o,
    output logic [DISPATCH_WIDTH-1:0]                 freeEntryValid_o,
    output logic [SIZE_ISSUEQ_LOG:0]                  freeCnt_o,
    output logic                                      iqFull_o,
    output logic                                      overflowErr_o
);

    localparam int unsigned LW = SIZE_ISSUEQ_LOG;
    localparam int unsigned CW = SIZE_ISSUEQ_LOG + 1;
    localparam logic [CW-1:0] CAP   = CW'(SIZE_ISSUEQ);
    localparam logic [CW:0]   CAP_X = (CW+1)'(SIZE_ISSUEQ);

    logic [LW-1:0] fl_q [SIZE_ISSUEQ];
    logic [LW-1:0] fl_d [SIZE_ISSUEQ];
    logic [LW-1:0] head_q, head_d;
    logic [LW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [CW-1:0] alloc_cnt;
    logic [CW-1:0] grant_cnt;
    logic          alloc_take;
    logic [CW-1:0] after_alloc;
    logic [CW:0]   reclaim_sum;
    logic          reclaim_ovf;
    logic [CW-1:0] rd_rank;
    logic [LW-1:0] rd_idx;
    logic [CW-1:0] wr_rank;
    logic [LW-1:0] wr_idx;

    // Lane popcounts for allocation demand and reclaim supply.
    always_comb begin
        alloc_cnt = '0;
        grant_cnt = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            alloc_cnt = alloc_cnt + CW'(dispatchLaneActive_i[i]);
        end
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            grant_cnt = grant_cnt + CW'(grantedValid_i[j]);
        end
    end

    // All-or-nothing stall and allocation decision; reclaim overflow check.
    always_comb begin
        iqFull_o    = (count_q < alloc_cnt);
        alloc_take  = dispatchReady_i & ~iqFull_o & ~flush_i;
        after_alloc = count_q - (alloc_take ? alloc_cnt : CW'(0));
        reclaim_sum = {1'b0, after_alloc} + {1'b0, grant_cnt};
        reclaim_ovf = (reclaim_sum > CAP_X);
    end

    // Offer: active lane i gets the entry at head + (active lanes below i).
    always_comb begin
        freeEntryId_o    = '0;
        freeEntryValid_o = '0;
        rd_rank          = '0;
        rd_idx           = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (dispatchLaneActive_i[i]) begin
                rd_idx                       = head_q + rd_rank[LW-1:0];
                freeEntryId_o[i*LW +: LW]    = fl_q[rd_idx];
                freeEntryValid_o[i]          = (rd_rank < count_q);
                rd_rank                      = rd_rank + CW'(1);
            end
        end
    end

    // Next state: flush refill, otherwise allocate and (unless overflowing) reclaim.
    always_comb begin
        fl_d       = fl_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_rank    = '0;
        wr_idx     = '0;
        if (flush_i) begin
            for (int i = 0; i < SIZE_ISSUEQ; i++) begin
                fl_d[i] = LW'(i);
            end
            head_d     = '0;
            tail_d     = '0;
            count_d    = CAP;
            overflow_d = 1'b0;
        end else begin
            if (alloc_take) begin
                head_d = head_q + alloc_cnt[LW-1:0];
            end
            if (reclaim_ovf) begin
                overflow_d = 1'b1;
                count_d    = after_alloc;
            end else begin
                for (int j = 0; j < ISSUE_WIDTH; j++) begin
                    if (grantedValid_i[j]) begin
                        wr_idx       = tail_q + wr_rank[LW-1:0];
                        fl_d[wr_idx] = grantedId_i[j*LW +: LW];
                        wr_rank      = wr_rank + CW'(1);
                    end
                end
                tail_d  = tail_q + grant_cnt[LW-1:0];
                count_d = reclaim_sum[CW-1:0];
            end
        end
    end

    // State registers with asynchronous reset to the all-free list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE_ISSUEQ; i++) begin
                fl_q[i] <= LW'(i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CAP;
            overflow_q <= 1'b0;
        end else begin
            fl_q       <= fl_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign freeCnt_o     = count_q;
    assign overflowErr_o = overflow_q;

endmodule

// File: tb/tb_iq_free_list.sv
// Bench for iq_free_list: directed scenarios followed by random traffic,
// all compared against a queue-based model of the free pool.
module tb_iq_free_list;

    localparam int N  = 32;
    localparam int DW = 4;
    localparam int IW = 4;
    localparam int LW = 5;

    logic            clk;
    logic            reset;
    logic            flush_i;
    logic            dispatchReady_i;
    logic [DW-1:0]   dispatchLaneActive_i;
    logic [IW-1:0]   grantedValid_i;
    logic [IW*LW-1:0] grantedId_i;
    logic [DW*LW-1:0] freeEntryId_o;
    logic [DW-1:0]   freeEntryValid_o;
    logic [LW:0]     freeCnt_o;
    logic            iqFull_o;
    logic            overflowErr_o;

    int checks   = 0;
    int failures = 0;

    // Model: free IDs in offer order, IDs currently held by the IQ, sticky error.
    int fq[$];
    int live[$];
    bit m_err;

    iq_free_list #(
        .SIZE_ISSUEQ(N), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW), .SIZE_ISSUEQ_LOG(LW)
    ) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .dispatchReady_i(dispatchReady_i),
        .dispatchLaneActive_i(dispatchLaneActive_i),
        .grantedValid_i(grantedValid_i), .grantedId_i(grantedId_i),
        .freeEntryId_o(freeEntryId_o), .freeEntryValid_o(freeEntryValid_o),
        .freeCnt_o(freeCnt_o), .iqFull_o(iqFull_o), .overflowErr_o(overflowErr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        live.delete();
        for (int i = 0; i < N; i++) fq.push_back(i);
        m_err = 1'b0;
    endtask

    function automatic bit in_live(input int id);
        foreach (live[i]) if (live[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    // Compare all outputs against the model's view of the current cycle.
    task automatic check_outputs(input string tag);
        int k;
        logic [DW*LW-1:0] eid;
        logic [DW*LW-1:0] mask;
        logic [DW-1:0]    ev;
        k = 0; eid = '0; mask = '0; ev = '0;
        for (int i = 0; i < DW; i++) begin
            if (dispatchLaneActive_i[i]) begin
                if (k < fq.size()) begin
                    ev[i] = 1'b1;
                    eid[i*LW +: LW] = LW'(fq[k]);
                    mask[i*LW +: LW] = '1;
                end
                k++;
            end else begin
                mask[i*LW +: LW] = '1;
            end
        end
        chk({tag, "_valid"}, 64'(freeEntryValid_o), 64'(ev));
        chk({tag, "_id"}, 64'(freeEntryId_o & mask), 64'(eid));
        chk({tag, "_cnt"}, 64'(freeCnt_o), 64'(fq.size()));
        chk({tag, "_full"}, 64'(iqFull_o), 64'(fq.size() < $countones(dispatchLaneActive_i)));
        chk({tag, "_err"}, 64'(overflowErr_o), 64'(m_err));
        chk({tag, "_cnt_le_cap"}, 64'(freeCnt_o <= (LW+1)'(N)), 64'(1));
        for (int i = 0; i < DW; i++) begin
            if (freeEntryValid_o[i])
                chk({tag, "_offer_not_live"}, 64'(in_live(int'(freeEntryId_o[i*LW +: LW]))), 64'(0));
        end
    endtask

    // Advance the model by one cycle using the currently driven inputs.
    task automatic model_update();
        int a;
        int f;
        int id;
        bit alloc;
        a = $countones(dispatchLaneActive_i);
        f = $countones(grantedValid_i);
        if (flush_i) begin
            model_reset();
            return;
        end
        alloc = dispatchReady_i && (fq.size() >= a);
        if (alloc) repeat (a) live.push_back(fq.pop_front());
        if (fq.size() + f > N) begin
            m_err = 1'b1;
        end else begin
            for (int j = 0; j < IW; j++) begin
                if (grantedValid_i[j]) begin
                    id = int'(grantedId_i[j*LW +: LW]);
                    fq.push_back(id);
                    for (int x = 0; x < live.size(); x++)
                        if (live[x] == id) begin live.delete(x); break; end
                end
            end
        end
    endtask

    // Called #1 after inputs settle at the falling edge; returns at the next falling edge.
    task automatic tick(input string tag);
        check_outputs(tag);
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cand[$];
        int idx;
        reset = 1'b1; flush_i = 1'b0; dispatchReady_i = 1'b0;
        dispatchLaneActive_i = 4'hF; grantedValid_i = '0; grantedId_i = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        chk("reset_ids", 64'(freeEntryId_o), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
        chk("reset_valid", 64'(freeEntryValid_o), 64'(4'hF));
        chk("reset_cnt", 64'(freeCnt_o), 64'(32));
        chk("reset_full", 64'(iqFull_o), 64'(0));
        tick("reset");

        // Drain to empty with 4-lane dispatch
        dispatchReady_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1; tick("drain");
        end
        dispatchReady_i = 1'b0;
        #1;
        chk("drain_cnt", 64'(freeCnt_o), 64'(0));
        chk("drain_full", 64'(iqFull_o), 64'(1));
        chk("drain_valid", 64'(freeEntryValid_o), 64'(0));

        // Reclaim 5 and 9 on lanes 1 and 3 while empty; dispatch attempt is blocked
        dispatchReady_i = 1'b1;
        grantedValid_i = 4'b1010;
        grantedId_i = {5'd9, 5'd0, 5'd5, 5'd0};
        #1; tick("reclaim_full");
        dispatchReady_i = 1'b0;
        grantedValid_i = '0;
        #1;
        chk("refill_cnt", 64'(freeCnt_o), 64'(2));
        chk("refill_valid", 64'(freeEntryValid_o), 64'(4'b0011));
        chk("refill_ids", 64'(freeEntryId_o[2*LW-1:0]), 64'({5'd9, 5'd5}));
        chk("refill_full4", 64'(iqFull_o), 64'(1));
        tick("refill");
        dispatchLaneActive_i = 4'b0011;
        #1;
        chk("refill_full2", 64'(iqFull_o), 64'(0));
        tick("refill2");

        // Asynchronous reset mid-cycle takes effect without a clock edge
        #2; reset = 1'b1;
        #1;
        chk("async_reset_cnt", 64'(freeCnt_o), 64'(32));
        chk("async_reset_err", 64'(overflowErr_o), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Sparse lanes
        dispatchLaneActive_i = 4'b1010;
        #1;
        chk("sparse_valid", 64'(freeEntryValid_o), 64'(4'b1010));
        chk("sparse_ids", 64'(freeEntryId_o), 64'({5'd1, 5'd0, 5'd0, 5'd0}));
        dispatchReady_i = 1'b1;
        tick("sparse");
        dispatchReady_i = 1'b0;
        dispatchLaneActive_i = 4'hF;
        #1;
        chk("sparse_cnt", 64'(freeCnt_o), 64'(30));
        chk("sparse_next", 64'(freeEntryId_o[LW-1:0]), 64'(2));
        tick("sparse_after");

        // Overflowing reclaim at count 30 is dropped and sets the sticky error
        grantedValid_i = 4'hF;
        grantedId_i = {5'd3, 5'd2, 5'd1, 5'd0};
        #1; tick("ovf");
        grantedValid_i = '0;
        #1;
        chk("ovf_err", 64'(overflowErr_o), 64'(1));
        chk("ovf_cnt", 64'(freeCnt_o), 64'(30));
        tick("ovf_after");

        // Flush overrides coincident dispatch and reclaim
        flush_i = 1'b1; dispatchReady_i = 1'b1;
        grantedValid_i = 4'hF; grantedId_i = {5'd20, 5'd21, 5'd22, 5'd23};
        #1; tick("flush");
        flush_i = 1'b0; dispatchReady_i = 1'b0; grantedValid_i = '0;
        #1;
        chk("flush_cnt", 64'(freeCnt_o), 64'(32));
        chk("flush_ids", 64'(freeEntryId_o), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
        chk("flush_err", 64'(overflowErr_o), 64'(0));
        tick("flush_after");

        // Random mixed traffic with legal (live, distinct) reclaims
        for (int c = 0; c < 2000; c++) begin
            dispatchLaneActive_i = 4'($urandom_range(0, 15));
            dispatchReady_i = ($urandom_range(0, 9) < 7);
            grantedValid_i = '0;
            grantedId_i = (IW*LW)'($urandom());
            cand = live;
            for (int j = 0; j < IW; j++) begin
                if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
                    idx = $urandom_range(0, cand.size() - 1);
                    grantedValid_i[j] = 1'b1;
                    grantedId_i[j*LW +: LW] = LW'(cand[idx]);
                    cand.delete(idx);
                end
            end
            #1; tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iq_free_list.md
# iq_free_list

Circular free list of issue-queue entry IDs, sitting directly upstream of the issue lanes. Each cycle it hands dispatch up to `DISPATCH_WIDTH` free IQ entry IDs, the `freeEntry` packets the lanes write into. It reclaims the IDs of entries granted by the per-lane select logic (`grantedEntry`). It also produces the IQ-full stall signal for dispatch.

## Interface
Parameters:
- `SIZE_ISSUEQ`, default 32: number of IQ entries; must be a power of 2.
- `DISPATCH_WIDTH`, default 4: allocation ports.
- `ISSUE_WIDTH`, default 4: reclaim ports, one per issue lane.
- `SIZE_ISSUEQ_LOG`, default 5: log2(`SIZE_ISSUEQ`).

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high.
- `flush_i`  in  1  synchronous refill to the all-free state.
- `dispatchReady_i`  in  1  dispatch wants to allocate this cycle.
- `dispatchLaneActive_i`  in  `DISPATCH_WIDTH`  lanes requesting an entry.
- `grantedValid_i`  in  `ISSUE_WIDTH`  per issue lane: entry granted, ID to be reclaimed.
- `grantedId_i`  in  `ISSUE_WIDTH`×`SIZE_ISSUEQ_LOG`  granted entry IDs.
- `freeEntryId_o`  out  `DISPATCH_WIDTH`×`SIZE_ISSUEQ_LOG`  ID offered to each dispatch lane.
- `freeEntryValid_o`  out  `DISPATCH_WIDTH`  the offered ID is real and allocatable.
- `freeCnt_o`  out  `SIZE_ISSUEQ_LOG`+1  current free-entry count.
- `iqFull_o`  out  1  fewer free entries than active dispatch lanes.
- `overflowErr_o`  out  1  sticky: a reclaim would exceed capacity.

## Operation
State:
- ID RAM `fl[SIZE_ISSUEQ]`.
- `head` and `tail` pointers, each `SIZE_ISSUEQ_LOG` bits, wrapping modulo `SIZE_ISSUEQ`.
- `count`, `SIZE_ISSUEQ_LOG`+1 bits.
- `overflowErr`.

Reset and flush:
- On reset: `fl[i]=i`, head=0, tail=0, count=`SIZE_ISSUEQ`, `overflowErr`=0.
- `flush_i` restores the same state synchronously. It has priority over allocation and reclaim in that cycle; both are dropped.

Offer (combinational from state):
- For active lane i, let k = number of active lanes below i.
- `freeEntryId_o[i]=fl[head+k]`.
- `freeEntryValid_o[i]` = active[i] & (k < count).
- Inactive lanes: valid=0, id=0.

Full:
- `iqFull_o` = (count < popcount(`dispatchLaneActive_i`)).
- Allocation is all-or-nothing. No partial dispatch.

Allocate:
- Condition: `dispatchReady_i` & !`iqFull_o` & !`flush_i`.
- head += A, where A = popcount(active).

Reclaim:
- Valid granted IDs are written at `tail`, `tail+1`, … in issue-lane order (lane 0 first), skipping invalid lanes.
- tail += F, where F = popcount(`grantedValid_i`).

Count update:
- count_next = count − A_taken + F.
- Reclaimed IDs are never offered in the same cycle. The offer uses only the pre-update count and head.

Overflow:
- If count − A_taken + F > `SIZE_ISSUEQ`, set `overflowErr_o` (held until reset or flush).
- In that cycle the pointers and count do not change for the reclaim part: F is treated as 0. Allocation still proceeds.

Duplicate-ID detection is not in scope; verification checks it with an assertion.

## Timing
- Offer-to-allocate is the same cycle: IDs and valids are stable combinationally from registered state.
- Reclaimed ID: granted in cycle N, earliest re-offered in cycle N+1.
- Allocation in cycle N is reflected in `freeCnt_o` in cycle N+1.
- Simultaneous alloc and reclaim in the same cycle are both applied. When count=0, reclaims still land and allocation is blocked by `iqFull_o`.
- Outputs after reset:
  - `freeEntryId_o[i]`=rank of lane i among active lanes (lane IDs 0..3 when all active).
  - `freeEntryValid_o`=`dispatchLaneActive_i`.
  - `freeCnt_o`=`SIZE_ISSUEQ`, `iqFull_o`=0, `overflowErr_o`=0.
- Reset asserted mid-operation restores the reset state immediately (asynchronous).

## Test plan
- **Reset:** reset, all lanes active -> ids 0,1,2,3 valid; `freeCnt_o`=32; `iqFull_o`=0.
- **Drain to full:** 8 cycles of 4-lane dispatch, no reclaim -> `freeCnt_o`=0; `iqFull_o`=1; all valids 0; head back to 0.
- **Reclaim while full:** at count 0, lanes 1 and 3 reclaim ids 5 and 9 with dispatch attempted -> no allocation. Next cycle: count=2, lane0 offered 5, lane1 offered 9. `iqFull_o`=1 with 4 lanes active, 0 with `dispatchLaneActive_i`=4'b0011.
- **Sparse lanes:** after reset, `dispatchLaneActive_i`=4'b1010 -> lane1 id 0, lane3 id 1, lanes 0/2 invalid. After dispatch, count=30 and next offer starts at id 2.
- **Wrap and mixed traffic:** random alloc/reclaim for 2000 cycles against a reference model. Requirements:
  - every offered ID matches the model;
  - no ID is live twice;
  - count is never above 32;
  - pointers wrap from 31 to 0 correctly.
- **Flush and overflow:** reclaim 4 IDs at count 30 -> `overflowErr_o`=1, count stays 30. Then `flush_i` coincident with dispatch and reclaim -> next cycle count=32, ids 0..3 offered, `overflowErr_o`=0.
